// File: rtl/rf_wport_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter slice.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package rf_wport_arbiter_pkg;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

   // Position of the ID stall request within the pipeline stall bus.
   localparam int STALL_W      = 6;
   localparam int STALL_IDX_ID = 1;

   // Source that owns the regfile write port in the current cycle.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_WB   = 2'd1,
      SEL_BUF  = 2'd2,
      SEL_BYP  = 2'd3
   } port_sel_e;

   // Width of the packed LU result bus {pc, waddr, wdata}.
   function automatic int lu_to_arb_wd(input int pc_w);
      return pc_w + RF_ADDR_W + RF_DATA_W;
   endfunction

   // Register match that ignores $0, which never carries a real dependency.
   function automatic logic addr_hit(input logic [RF_ADDR_W-1:0] id_addr,
                                     input logic [RF_ADDR_W-1:0] pend_addr);
      return (id_addr != '0) && (id_addr == pend_addr);
   endfunction

endpackage

// File: rtl/rf_wbuf_fifo.sv
// FIFO of LU results waiting for a free regfile write slot; exposes per-entry valid/waddr.
// Latency: push visible at head the cycle after the write; head_dat_o is a direct read.
// Backpressure: caller must not push when count_o==DEPTH nor pop when count_o==0.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i, push_dat_i  write an entry {pc, waddr, wdata} at the tail
//   pop_i               retire the head entry
//   head_dat_o          oldest entry
//   count_o             number of occupied entries (0..DEPTH)
//   ent_vld_o           per-slot occupancy
//   ent_waddr_o         per-slot destination register
module rf_wbuf_fifo
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 69
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                push_i,
   input  logic [W-1:0]                        push_dat_i,
   input  logic                                pop_i,
   output logic [W-1:0]                        head_dat_o,
   output logic [$clog2(DEPTH):0]              count_o,
   output logic [DEPTH-1:0]                    ent_vld_o,
   output logic [DEPTH-1:0][RF_ADDR_W-1:0]     ent_waddr_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [DEPTH-1:0] vld_q, vld_d;

   // Pointers are PW bits wide, so the +1 wraps modulo DEPTH for free.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      vld_d   = vld_q;
      if (push_i) begin
         tail_d        = tail_q + PW'(1);
         vld_d[tail_q] = 1'b1;
      end
      if (pop_i) begin
         head_d        = head_q + PW'(1);
         vld_d[head_q] = 1'b0;
      end
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Payload needs no reset: vld_q gates every use of it.
   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[tail_q] <= push_dat_i;
      end
   end

   assign head_dat_o = mem_q[head_q];
   assign count_o    = count_q;
   assign ent_vld_o  = vld_q;

   for (genvar i = 0; i < DEPTH; i++) begin : g_waddr
      assign ent_waddr_o[i] = mem_q[i][RF_DATA_W +: RF_ADDR_W];
   end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the regfile write port between WB (always wins) and a buffered long-latency unit.
// Latency: WB and LU bypass write in the same cycle; buffered LU results drain on free WB slots.
// Backpressure: lu_ready drops when the buffer is full (registered state only); ID stalls on pending LU writes.
//
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   wb_we/wb_waddr/wb_wdata/wb_pc       in-order writeback request
//   lu_valid/lu_ready/lu_waddr/...      long-latency unit result handshake
//   id_raddr1/id_raddr2/id_waddr/id_we  decode-stage register usage
//   stallreq_id                         decode must hold (pending LU write hazard)
//   rf_we/rf_waddr/rf_wdata             regfile write port
//   debug_wb_*                          trace of the write performed this cycle
module rf_wport_arbiter
   import rf_wport_arbiter_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  wb_we,
   input  logic [RF_ADDR_W-1:0]  wb_waddr,
   input  logic [RF_DATA_W-1:0]  wb_wdata,
   input  logic [PC_W-1:0]       wb_pc,
   input  logic                  lu_valid,
   output logic                  lu_ready,
   input  logic [RF_ADDR_W-1:0]  lu_waddr,
   input  logic [RF_DATA_W-1:0]  lu_wdata,
   input  logic [PC_W-1:0]       lu_pc,
   input  logic [RF_ADDR_W-1:0]  id_raddr1,
   input  logic [RF_ADDR_W-1:0]  id_raddr2,
   input  logic [RF_ADDR_W-1:0]  id_waddr,
   input  logic                  id_we,
   output logic                  stallreq_id,
   output logic                  rf_we,
   output logic [RF_ADDR_W-1:0]  rf_waddr,
   output logic [RF_DATA_W-1:0]  rf_wdata,
   output logic [PC_W-1:0]       debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [RF_ADDR_W-1:0]  debug_wb_rf_wnum,
   output logic [RF_DATA_W-1:0]  debug_wb_rf_wdata
);

   localparam int ENT_W = lu_to_arb_wd(PC_W);
   localparam int CW    = $clog2(DEPTH) + 1;

   port_sel_e                       sel;
   logic                            wb_hit;
   logic                            lu_zero;
   logic                            bypass;
   logic                            push;
   logic                            pop;
   logic [ENT_W-1:0]                lu_bus;
   logic [ENT_W-1:0]                head_dat;
   logic [CW-1:0]                   count;
   logic [DEPTH-1:0]                ent_vld;
   logic [DEPTH-1:0][RF_ADDR_W-1:0] ent_waddr;
   logic [RF_ADDR_W-1:0]            id_wa;
   logic                            hazard;

   assign lu_bus  = {lu_pc, lu_waddr, lu_wdata};
   assign wb_hit  = wb_we && (wb_waddr != '0);
   assign lu_zero = (lu_waddr == '0);

   // Port priority: real WB write, then oldest buffered LU result, then LU bypass.
   // Bypass is only legal with an empty buffer so LU writes retire in order.
   always_comb begin
      sel = SEL_NONE;
      if (!resetn) begin
         sel = SEL_NONE;
      end else if (wb_hit) begin
         sel = SEL_WB;
      end else if (count != '0) begin
         sel = SEL_BUF;
      end else if (lu_valid && !lu_zero) begin
         sel = SEL_BYP;
      end
   end

   // Ready is from registered occupancy only: a pop this cycle frees space next cycle.
   assign lu_ready = resetn && (count != CW'(DEPTH));
   assign bypass   = (sel == SEL_BYP);
   assign pop      = (sel == SEL_BUF);
   // $0 results complete the handshake but are dropped here.
   assign push     = lu_valid && lu_ready && !bypass && !lu_zero;

   rf_wbuf_fifo #(
      .DEPTH (DEPTH),
      .W     (ENT_W)
   ) u_wbuf (
      .clk_i       (clk),
      .rst_ni      (resetn),
      .push_i      (push),
      .push_dat_i  (lu_bus),
      .pop_i       (pop),
      .head_dat_o  (head_dat),
      .count_o     (count),
      .ent_vld_o   (ent_vld),
      .ent_waddr_o (ent_waddr)
   );

   always_comb begin
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      debug_wb_pc = '0;
      case (sel)
         SEL_WB: begin
            rf_we       = 1'b1;
            rf_waddr    = wb_waddr;
            rf_wdata    = wb_wdata;
            debug_wb_pc = wb_pc;
         end
         SEL_BUF: begin
            rf_we       = 1'b1;
            rf_waddr    = head_dat[RF_DATA_W +: RF_ADDR_W];
            rf_wdata    = head_dat[RF_DATA_W-1:0];
            debug_wb_pc = head_dat[ENT_W-1 -: PC_W];
         end
         SEL_BYP: begin
            rf_we       = 1'b1;
            rf_waddr    = lu_waddr;
            rf_wdata    = lu_wdata;
            debug_wb_pc = lu_pc;
         end
         default: ;
      endcase
   end

   assign debug_wb_rf_wen   = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   // The entry popped this cycle still counts: decode reads the regfile
   // combinationally, so the value is only safe from the next cycle on.
   // A waiting LU result that is not bypassed is also pending.
   always_comb begin
      id_wa  = id_we ? id_waddr : '0;
      hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ent_vld[i]) begin
            hazard = hazard
                   | addr_hit(id_raddr1, ent_waddr[i])
                   | addr_hit(id_raddr2, ent_waddr[i])
                   | addr_hit(id_wa,     ent_waddr[i]);
         end
      end
      if (lu_valid && !bypass) begin
         hazard = hazard
                | addr_hit(id_raddr1, lu_waddr)
                | addr_hit(id_raddr2, lu_waddr)
                | addr_hit(id_wa,     lu_waddr);
      end
   end

   assign stallreq_id = resetn && hazard;

endmodule
